// File: rtl/outer_prod_engine_pkg.sv
// Shared sizing and state encoding for the outer-product compute core.
// Operands are DW-bit unsigned; products are full 2*DW-bit width.
package outer_prod_engine_pkg;
  localparam int N     = 16;
  localparam int DW    = 4;
  localparam int PW    = 2 * DW;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N * N);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC
  } state_t;
endpackage

// File: rtl/ope_operand_bank.sv
// N-entry A/B operand store: one indexed write port for loading and two
// combinational read ports (A by row, B by col).
module ope_operand_bank
  import outer_prod_engine_pkg::*;
(
  input  logic             clk2,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [DW-1:0]    i_wr_a,
  input  logic [DW-1:0]    i_wr_b,
  input  logic [IDX_W-1:0] i_rd_row,
  input  logic [IDX_W-1:0] i_rd_col,
  output logic [DW-1:0]    o_rd_a,
  output logic [DW-1:0]    o_rd_b
);
  logic [DW-1:0] r_a [N];
  logic [DW-1:0] r_b [N];

  // Operand contents are don't-care after reset, so no reset term here.
  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    always_ff @(posedge clk2) begin
      if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
        r_a[gi] <= i_wr_a;
        r_b[gi] <= i_wr_b;
      end
    end
  end

  assign o_rd_a = r_a[i_rd_row];
  assign o_rd_b = r_b[i_rd_col];
endmodule

// File: rtl/outer_prod_engine.sv
// Loads N A/B pairs, then streams C[i*N+j] = A[i]*B[j] row-major under
// valid/ready backpressure; returns to IDLE on the final transfer.
module outer_prod_engine
  import outer_prod_engine_pkg::*;
(
  input  logic          clk2,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_matrix_A,
  input  logic [DW-1:0] in_matrix_B,
  output logic          busy,
  output logic          out_valid,
  output logic [PW-1:0] out_matrix,
  input  logic          out_ready
);
  state_t r_state, w_state_next;
  logic [IDX_W-1:0] r_load_cnt, w_load_cnt_next;
  logic [IDX_W-1:0] r_row, w_row_next;
  logic [IDX_W-1:0] r_col, w_col_next;
  logic             r_out_valid, w_out_valid_next;
  logic [PW-1:0]    r_out_matrix, w_out_matrix_next;
  logic             r_busy, w_busy_next;

  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_adv_row, w_adv_col, w_rd_row, w_rd_col;
  logic [DW-1:0]    w_op_a, w_op_b;
  logic [PW-1:0]    w_product;
  logic             w_xfer, w_col_end, w_last;

  assign w_xfer    = r_out_valid & out_ready;
  assign w_col_end = (r_col == IDX_W'(N - 1));
  assign w_last    = w_col_end & (r_row == IDX_W'(N - 1));
  assign w_adv_col = w_col_end ? '0 : r_col + 1'b1;
  assign w_adv_row = w_col_end ? r_row + 1'b1 : r_row;

  // Read the indices that will be current after this edge, so the output
  // register always loads the product matching the advanced (row, col).
  assign w_rd_row  = w_xfer ? w_adv_row : r_row;
  assign w_rd_col  = w_xfer ? w_adv_col : r_col;
  assign w_product = PW'(w_op_a) * PW'(w_op_b);

  ope_operand_bank u_bank (
    .clk2     (clk2),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_wr_idx),
    .i_wr_a   (in_matrix_A),
    .i_wr_b   (in_matrix_B),
    .i_rd_row (w_rd_row),
    .i_rd_col (w_rd_col),
    .o_rd_a   (w_op_a),
    .o_rd_b   (w_op_b)
  );

  always_comb begin
    w_state_next      = r_state;
    w_load_cnt_next   = r_load_cnt;
    w_row_next        = r_row;
    w_col_next        = r_col;
    w_out_valid_next  = r_out_valid;
    w_out_matrix_next = r_out_matrix;
    w_busy_next       = r_busy;
    w_wr_en           = 1'b0;
    w_wr_idx          = r_load_cnt;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_wr_en         = 1'b1;
          w_wr_idx        = '0;
          w_load_cnt_next = IDX_W'(1);
          w_busy_next     = 1'b1;
          w_state_next    = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          w_wr_en = 1'b1;
          if (r_load_cnt == IDX_W'(N - 1)) begin
            // Row/col are still 0 here, so this is A[0]*B[0].
            w_load_cnt_next   = '0;
            w_out_valid_next  = 1'b1;
            w_out_matrix_next = w_product;
            w_state_next      = CALC;
          end else begin
            w_load_cnt_next = r_load_cnt + 1'b1;
          end
        end
      end
      CALC: begin
        if (w_xfer) begin
          if (w_last) begin
            w_row_next        = '0;
            w_col_next        = '0;
            w_out_valid_next  = 1'b0;
            w_out_matrix_next = '0;
            w_busy_next       = 1'b0;
            w_state_next      = IDLE;
          end else begin
            w_row_next        = w_adv_row;
            w_col_next        = w_adv_col;
            w_out_matrix_next = w_product;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state      <= IDLE;
      r_load_cnt   <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_out_valid  <= 1'b0;
      r_out_matrix <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_load_cnt   <= w_load_cnt_next;
      r_row        <= w_row_next;
      r_col        <= w_col_next;
      r_out_valid  <= w_out_valid_next;
      r_out_matrix <= w_out_matrix_next;
      r_busy       <= w_busy_next;
    end
  end

  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign out_matrix = r_out_matrix;
endmodule

// File: tb/tb_outer_prod_engine.sv
// Scoreboard bench: the driver pushes every product it expects (A[i]*B[j],
// row-major) and an independent negedge monitor pops on each transfer.
module tb_outer_prod_engine;
  import outer_prod_engine_pkg::*;

  logic          clk2 = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_matrix_A;
  logic [DW-1:0] in_matrix_B;
  logic          busy;
  logic          out_valid;
  logic [PW-1:0] out_matrix;
  logic          out_ready;

  outer_prod_engine dut (
    .clk2        (clk2),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_matrix_A (in_matrix_A),
    .in_matrix_B (in_matrix_B),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_matrix  (out_matrix),
    .out_ready   (out_ready)
  );

  always #5 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int got[N*N];
  logic [CNT_W:0] rx_idx = '0;
  int ma[N];
  int mb[N];
  int bp_mode = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // out_ready: 0 = always 1, 1 = pattern 1,0,0,1, 2 = random
  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk2);
      #1;
      case (bp_mode)
        1:       out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: sampled on the falling edge, well away from the active edge.
  initial begin
    logic hold_pending = 1'b0;
    int   prev_val     = 0;
    forever begin
      @(negedge clk2);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_value", int'(out_matrix), prev_val);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            chk("product", int'(out_matrix), exp_q.pop_front());
          end
          if (rx_idx < (N * N)) got[rx_idx] = int'(out_matrix);
          rx_idx = rx_idx + 1'b1;
        end else if (!out_valid) begin
          chk("zero_when_invalid", int'(out_matrix), 0);
        end
        hold_pending = out_valid && !out_ready;
        prev_val     = int'(out_matrix);
      end
    end
  end

  // Entered and left at posedge+1. Pushes the whole expected stream once
  // the last pair has been captured.
  task automatic load_matrix(input int gap_at, input int gap_len);
    for (int k = 0; k < N; k++) begin
      if (k == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) begin
          @(posedge clk2);
          #1;
        end
      end
      if (k == N - 1) chk("valid_before_last_capture", int'(out_valid), 0);
      in_valid    = 1'b1;
      in_matrix_A = DW'(ma[k]);
      in_matrix_B = DW'(mb[k]);
      @(posedge clk2);
      #1;
    end
    in_valid = 1'b0;
    chk("first_product_latency", int'(out_valid), 1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_q.push_back(ma[i] * mb[j]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk2);
      #1;
      n++;
    end
    chk({name, "_timeout"}, int'(exp_q.size() != 0), 0);
    chk({name, "_busy_after_last"}, int'(busy), 0);
    chk({name, "_valid_after_last"}, int'(out_valid), 0);
    chk({name, "_count"}, int'(rx_idx), N * N);
    $display("stream %s: %0d products received, checks=%0d", name, rx_idx, checks);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_matrix_A = '0;
    in_matrix_B = '0;
    repeat (3) @(posedge clk2);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_matrix", int'(out_matrix), 0);
    rst = 1'b0;
    @(posedge clk2);
    #1;

    // Basic run
    for (int k = 0; k < N; k++) begin ma[k] = k; mb[k] = 15 - k; end
    rx_idx = '0;
    load_matrix(-1, 0);
    chk("busy_during_calc", int'(busy), 1);
    wait_done("basic");
    chk("c0", got[0], 0);
    chk("c17", got[17], 14);
    chk("c255", got[255], 0);
    chk("c240", got[240], 225);

    // Back-to-back all-ones, with in_valid pulsed during CALC
    for (int k = 0; k < N; k++) begin ma[k] = 1; mb[k] = 1; end
    rx_idx = '0;
    load_matrix(-1, 0);
    repeat (5) begin @(posedge clk2); #1; end
    in_matrix_A = '0;
    in_matrix_B = '0;
    in_valid    = 1'b1;
    repeat (3) begin @(posedge clk2); #1; end
    in_valid = 1'b0;
    wait_done("b2b_ignored");

    // Gapped load
    for (int k = 0; k < N; k++) begin ma[k] = k; mb[k] = 15 - k; end
    rx_idx = '0;
    load_matrix(8, 3);
    wait_done("gapped");

    // Backpressure with 1,0,0,1 pattern
    for (int k = 0; k < N; k++) begin ma[k] = 15; mb[k] = 15; end
    bp_mode = 1;
    rx_idx  = '0;
    load_matrix(-1, 0);
    wait_done("backpressure");

    // Random data under random backpressure
    for (int k = 0; k < N; k++) begin
      ma[k] = int'($urandom_range(0, 15));
      mb[k] = int'($urandom_range(0, 15));
    end
    bp_mode = 2;
    rx_idx  = '0;
    load_matrix(int'($urandom_range(1, N - 1)), int'($urandom_range(1, 4)));
    wait_done("random");

    // Mid-run reset at transfer #100
    bp_mode = 0;
    for (int k = 0; k < N; k++) begin
      ma[k] = int'($urandom_range(0, 15));
      mb[k] = int'($urandom_range(0, 15));
    end
    rx_idx = '0;
    load_matrix(-1, 0);
    n = 0;
    while (rx_idx < 100 && n < 1000) begin
      @(posedge clk2);
      #1;
      n++;
    end
    chk("midrst_reach_100", int'(rx_idx >= 100), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk2);
    #1;
    rst = 1'b0;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_matrix", int'(out_matrix), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (2) begin @(posedge clk2); #1; end
    chk("midrst_quiet", int'(out_valid), 0);
    for (int k = 0; k < N; k++) begin ma[k] = 2; mb[k] = 3; end
    rx_idx = '0;
    load_matrix(-1, 0);
    wait_done("after_reset");
    chk("after_reset_c0", got[0], 6);
    chk("after_reset_c255", got[255], 6);

    repeat (3) begin @(posedge clk2); #1; end
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
